// File: rtl/counter_up_sched_if.sv
// Request/grant bundle between two requesters and the shared counter scheduler.
// Handshake: req is a level valid per requester. The matching gnt bit is the accept:
// from the cycle gnt rises until the cycle after the done pulse, req/tgt are don't-care.
interface counter_up_sched_if;
  logic [1:0] req;
  logic [1:0] tgt0;
  logic [1:0] tgt1;
  logic [1:0] gnt;
  logic       cnt_en;
  logic [1:0] count;
  logic       busy;
  logic [1:0] done;

  modport master (output req, tgt0, tgt1, input gnt, cnt_en, count, busy, done);
  modport slave  (input req, tgt0, tgt1, output gnt, cnt_en, count, busy, done);
endinterface

// File: rtl/counter_up_sched.sv
// Round-robin scheduler that grants one of two requesters a burst of 1..4 increments
// of a shared 2-bit counter, spacing the strobes GAP idle cycles apart.
module counter_up_sched #(
  parameter int GAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  counter_up_sched_if.slave  bus,
  output logic [1:0]         o_state
);
  // o_state encoding is a debug contract: IDLE reads as 0.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [2:0] GAP_M1 = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  logic [1:0] r_state;
  logic [1:0] r_gnt;
  logic       r_cnt_en;
  logic [1:0] r_count;
  logic       r_busy;
  logic [1:0] r_done;
  logic [2:0] r_rem;
  logic [2:0] r_gap;
  logic       r_last;
  logic [1:0] w_state_nxt;
  logic       w_sel1;
  logic [1:0] w_tgt_sel;

  // r_last is the requester served last; on a tie the other one wins.
  always_comb begin
    w_sel1      = bus.req[1] & (~bus.req[0] | ~r_last);
    w_tgt_sel   = w_sel1 ? bus.tgt1 : bus.tgt0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.req != 2'b00) w_state_nxt = RUN;
      RUN: begin
        if (r_rem == 3'd1)  w_state_nxt = DONE;
        else if (GAP == 0)  w_state_nxt = RUN;
        else                w_state_nxt = WAIT;
      end
      WAIT: if (r_gap == 3'd0) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= 2'b00;
      r_cnt_en <= 1'b0;
      r_count  <= 2'd0;
      r_busy   <= 1'b0;
      r_done   <= 2'b00;
      r_rem    <= 3'd0;
      r_gap    <= 3'd0;
      r_last   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt_en <= (w_state_nxt == RUN);
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= (w_state_nxt == DONE) ? r_gnt : 2'b00;
      if (r_cnt_en) r_count <= r_count + 2'd1;
      case (r_state)
        IDLE: begin
          if (w_state_nxt == RUN) begin
            r_gnt <= w_sel1 ? 2'b10 : 2'b01;
            r_rem <= {1'b0, w_tgt_sel} + 3'd1;
          end
        end
        RUN: begin
          r_rem <= r_rem - 3'd1;
          r_gap <= GAP_M1;
        end
        WAIT: if (r_gap != 3'd0) r_gap <= r_gap - 3'd1;
        default: begin
          r_gnt  <= 2'b00;
          r_last <= r_gnt[1];
        end
      endcase
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.cnt_en = r_cnt_en;
  assign bus.count  = r_count;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign o_state    = r_state;
endmodule

// File: tb/tb_counter_up_sched.sv
// Bench for counter_up_sched: GAP=0 and GAP=1 instances share stimulus; a schedule-level
// model predicts every output cycle of the instance selected by sel.
module tb_counter_up_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b1;
  logic [1:0] req_drv = 2'b00;
  logic [1:0] tgt0_drv = 2'd0;
  logic [1:0] tgt1_drv = 2'd0;
  logic [1:0] st0, st1;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  counter_up_sched_if bus0();
  counter_up_sched_if bus1();
  assign bus0.req = req_drv;  assign bus0.tgt0 = tgt0_drv;  assign bus0.tgt1 = tgt1_drv;
  assign bus1.req = req_drv;  assign bus1.tgt0 = tgt0_drv;  assign bus1.tgt1 = tgt1_drv;

  counter_up_sched #(.GAP(0)) dut_g0 (.clk(clk), .rst(rst), .bus(bus0), .o_state(st0));
  counter_up_sched #(.GAP(1)) dut_g1 (.clk(clk), .rst(rst), .bus(bus1), .o_state(st1));

  // Observed vector layout: {gnt[1:0], cnt_en, count[1:0], busy, done[1:0]}
  wire [7:0] obs_v = sel ? {bus1.gnt, bus1.cnt_en, bus1.count, bus1.busy, bus1.done}
                         : {bus0.gnt, bus0.cnt_en, bus0.count, bus0.busy, bus0.done};
  wire [1:0] obs_gnt   = obs_v[7:6];
  wire       obs_en    = obs_v[5];
  wire [1:0] obs_count = obs_v[4:3];
  wire       obs_busy  = obs_v[2];
  wire [1:0] obs_done  = obs_v[1:0];
  wire [1:0] obs_st    = sel ? st1 : st0;

  // Model: a grant taken at edge t0 for N steps occupies cycles t0..d, d = t0+(N-1)(G+1)+1;
  // strobes fall on cycles t0+k(G+1) below d, done on d, and one idle cycle follows.
  int cyc = 0, m_t0 = 0, m_d = 0, m_n = 0, tot_steps = 0, served0 = 0, served1 = 0;
  bit m_active = 0, m_g = 0, m_last = 1;
  logic [1:0] m_count = 2'd0;
  logic [1:0] exp_gnt = 2'b00, exp_count = 2'd0, exp_done = 2'b00;
  logic exp_en = 1'b0, exp_busy = 1'b0;
  wire [7:0] exp_v = {exp_gnt, exp_en, exp_count, exp_busy, exp_done};

  always @(posedge clk or posedge rst) begin
    int gap_sel;
    gap_sel = sel ? 1 : 0;
    if (rst) begin
      cyc = 0; m_active = 0; m_last = 1; m_count = 2'd0;
      tot_steps = 0; served0 = 0; served1 = 0;
      exp_gnt = 2'b00; exp_en = 1'b0; exp_count = 2'd0; exp_busy = 1'b0; exp_done = 2'b00;
    end else begin
      cyc++;
      if (exp_en) m_count = m_count + 2'd1;
      if (m_active && cyc > m_d) begin
        m_active = 0;
        m_last = m_g;
      end else if (!m_active && req_drv != 2'b00) begin
        m_g = (req_drv == 2'b11) ? !m_last : req_drv[1];
        m_n = (m_g ? int'(tgt1_drv) : int'(tgt0_drv)) + 1;
        m_t0 = cyc;
        m_d = cyc + (m_n - 1) * (gap_sel + 1) + 1;
        m_active = 1;
        tot_steps += m_n;
        if (m_g) served1++; else served0++;
      end
      exp_gnt   = m_active ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      exp_busy  = m_active;
      exp_en    = m_active && (cyc < m_d) && (((cyc - m_t0) % (gap_sel + 1)) == 0);
      exp_done  = (m_active && cyc == m_d) ? exp_gnt : 2'b00;
      exp_count = m_count;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_drv = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if (obs_v !== 8'h00 || st0 !== 2'd0 || st1 !== 2'd0) begin
      n_fail++; $display("FAIL reset_hold got=%b st0=%0d st1=%0d exp=00000000 st=0", obs_v, st0, st1);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v || obs_v !== 8'h00) begin
        n_fail++; $display("FAIL reset_idle got=%b exp=%b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_single_gap1();
    int pos_q[$];
    int dones;
    sel = 1'b1;
    do_reset();
    req_drv = 2'b01; tgt0_drv = 2'd2; tgt1_drv = 2'($urandom_range(0, 3));
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_drv = 2'b00;
        n_chk++;
        if (obs_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt got=%b exp=01", obs_gnt); end
      end
      n_chk++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL single_trace i=%0d got=%b exp=%b", i, obs_v, exp_v); end
      if (obs_en) pos_q.push_back(i);
      if (obs_done != 2'b00) begin
        dones++;
        n_chk++;
        if (obs_done !== 2'b01 || i != 5) begin n_fail++; $display("FAIL single_done i=%0d got=%b exp=01 at i=5", i, obs_done); end
      end
    end
    n_chk++;
    if (pos_q.size() != 3 || pos_q[0] != 0 || pos_q[1] != 2 || pos_q[2] != 4) begin
      n_fail++; $display("FAIL single_spacing got=%p exp='{0,2,4}", pos_q);
    end
    n_chk++;
    if (dones != 1 || obs_count !== 2'd3 || obs_busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end got dones=%0d count=%0d busy=%b exp 1 3 0", dones, obs_count, obs_busy);
    end
  endtask

  task automatic test_rr_gap0();
    logic [1:0] exp_q[$];
    logic [1:0] prev_gnt;
    sel = 1'b0;
    do_reset();
    exp_q = '{2'b01, 2'b10, 2'b01};
    prev_gnt = 2'b00;
    req_drv = 2'b11; tgt0_drv = 2'd0; tgt1_drv = 2'd3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 10) req_drv = 2'b00;
      n_chk++;
      if (obs_v !== exp_v || obs_gnt === 2'b11) begin
        n_fail++; $display("FAIL rr_trace i=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
      if (obs_gnt != 2'b00 && prev_gnt == 2'b00 && exp_q.size() > 0) begin
        logic [1:0] want;
        want = exp_q.pop_front();
        n_chk++;
        if (obs_gnt !== want) begin n_fail++; $display("FAIL rr_order got=%b exp=%b", obs_gnt, want); end
      end
      prev_gnt = obs_gnt;
    end
    n_chk++;
    if (exp_q.size() != 0 || obs_count !== 2'd2) begin
      n_fail++; $display("FAIL rr_end got pending=%0d count=%0d exp 0 2", exp_q.size(), obs_count);
    end
  endtask

  task automatic test_wrap_gap0();
    int pulses;
    logic [1:0] done_seen;
    sel = 1'b0;
    do_reset();
    req_drv = 2'b01; tgt0_drv = 2'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_drv = 2'b00;
      n_chk++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL wrap_pre i=%0d got=%b exp=%b", i, obs_v, exp_v); end
    end
    n_chk++;
    if (obs_count !== 2'd3) begin n_fail++; $display("FAIL wrap_setup got=%0d exp=3", obs_count); end
    req_drv = 2'b01; tgt0_drv = 2'd0;
    pulses = 0; done_seen = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_drv = 2'b00;
      n_chk++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL wrap_trace i=%0d got=%b exp=%b", i, obs_v, exp_v); end
      if (obs_en) pulses++;
      done_seen = done_seen | obs_done;
    end
    n_chk++;
    if (pulses != 1 || obs_count !== 2'd0 || done_seen !== 2'b01) begin
      n_fail++; $display("FAIL wrap_end got pulses=%0d count=%0d done=%b exp 1 0 01", pulses, obs_count, done_seen);
    end
  endtask

  task automatic test_drop_req();
    int pulses, dones;
    sel = 1'b1;
    do_reset();
    req_drv = 2'b01; tgt0_drv = 2'd3;
    pulses = 0; dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) begin req_drv = 2'b00; tgt0_drv = 2'd0; end
      n_chk++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL drop_trace i=%0d got=%b exp=%b", i, obs_v, exp_v); end
      if (obs_en) pulses++;
      if (obs_done === 2'b01) dones++;
    end
    n_chk++;
    if (pulses != 4 || dones != 1) begin
      n_fail++; $display("FAIL drop_end got pulses=%0d dones=%0d exp 4 1", pulses, dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones, pulses;
    bit first_en, first_gnt;
    sel = 1'b1;
    do_reset();
    req_drv = 2'b01; tgt0_drv = 2'd3;
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      req_drv = 2'b00;
      n_chk++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL mid_pre got=%b exp=%b", obs_v, exp_v); end
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (obs_v !== 8'h00 || obs_st !== 2'd0) begin
      n_fail++; $display("FAIL mid_async got=%b st=%0d exp=00000000 st=0", obs_v, obs_st);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v || obs_done !== 2'b00) begin n_fail++; $display("FAIL mid_idle got=%b exp=%b", obs_v, exp_v); end
    end
    req_drv = 2'b10; tgt1_drv = 2'd1;
    first_en = 1; first_gnt = 1; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_drv = 2'b00;
      n_chk++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL mid_trace i=%0d got=%b exp=%b", i, obs_v, exp_v); end
      if (first_gnt && obs_gnt != 2'b00) begin
        first_gnt = 0;
        n_chk++;
        if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL mid_gnt got=%b exp=10", obs_gnt); end
      end
      if (first_en && obs_en) begin
        first_en = 0;
        n_chk++;
        if (obs_count !== 2'd0) begin n_fail++; $display("FAIL mid_count0 got=%0d exp=0", obs_count); end
      end
      if (obs_en) pulses++;
      if (obs_done != 2'b00) dones++;
    end
    n_chk++;
    if (dones != 1 || pulses != 2 || obs_count !== 2'd2) begin
      n_fail++; $display("FAIL mid_end got dones=%0d pulses=%0d count=%0d exp 1 2 2", dones, pulses, obs_count);
    end
  endtask

  task automatic test_random();
    int pulses;
    bit drained;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      pulses = 0;
      for (int i = 0; i < 1000; i++) begin
        req_drv  = 2'($urandom_range(0, 3));
        tgt0_drv = 2'($urandom_range(0, 3));
        tgt1_drv = 2'($urandom_range(0, 3));
        @(negedge clk);
        n_chk++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL rand_trace sel=%0d i=%0d got=%b exp=%b", s, i, obs_v, exp_v); end
        if (obs_en) pulses++;
      end
      req_drv = 2'b00;
      drained = 0;
      for (int i = 0; i < 40 && !drained; i++) begin
        @(negedge clk);
        n_chk++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL rand_drain sel=%0d got=%b exp=%b", s, obs_v, exp_v); end
        if (obs_en) pulses++;
        if (!obs_busy) drained = 1;
      end
      n_chk++;
      if (!drained) begin n_fail++; $display("FAIL rand_timeout sel=%0d busy=%b exp=0", s, obs_busy); end
      n_chk++;
      if (pulses != tot_steps || obs_count !== 2'(tot_steps % 4)) begin
        n_fail++; $display("FAIL rand_sum sel=%0d got pulses=%0d count=%0d exp %0d %0d", s, pulses, obs_count, tot_steps, tot_steps % 4);
      end
      n_chk++;
      if (served0 == 0 || served1 == 0) begin
        n_fail++; $display("FAIL rand_served sel=%0d got %0d/%0d exp both nonzero", s, served0, served1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog time=%0t exp=finished", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_gap1();
    test_rr_gap0();
    test_wrap_gap0();
    test_drop_req();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
